// File: rtl/acappella_core.sv
// Records {left,right} ADC pairs into SDRAM and plays them back to the DAC. Each word costs one SDRAM access.
// SDRAM strobes are held until waitrequest is low. DAC valids are held until each channel's ready, and the next read waits for both channels.
module acappella_core #(
    parameter int                ADDR_W   = 23,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 23'h7FFFFF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [3:0]        KEY,
    input  logic [17:0]       SW,
    output logic [8:0]        LEDG,
    output logic              from_adc_left_channel_ready,
    input  logic [15:0]       from_adc_left_channel_data,
    input  logic              from_adc_left_channel_valid,
    output logic              from_adc_right_channel_ready,
    input  logic [15:0]       from_adc_right_channel_data,
    input  logic              from_adc_right_channel_valid,
    output logic [15:0]       to_dac_left_channel_data,
    output logic              to_dac_left_channel_valid,
    input  logic              to_dac_left_channel_ready,
    output logic [15:0]       to_dac_right_channel_data,
    output logic              to_dac_right_channel_valid,
    input  logic              to_dac_right_channel_ready,
    output logic [ADDR_W-1:0] new_sdram_controller_0_s1_address,
    output logic [3:0]        new_sdram_controller_0_s1_byteenable_n,
    output logic              new_sdram_controller_0_s1_chipselect,
    output logic [31:0]       new_sdram_controller_0_s1_writedata,
    output logic              new_sdram_controller_0_s1_read_n,
    output logic              new_sdram_controller_0_s1_write_n,
    input  logic [31:0]       new_sdram_controller_0_s1_readdata,
    input  logic              new_sdram_controller_0_s1_readdatavalid,
    input  logic              new_sdram_controller_0_s1_waitrequest
);
    typedef enum logic [2:0] {
        IDLE, REC_CAPTURE, REC_WRITE, PLAY_READ, PLAY_WAIT, PLAY_OUT
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        key_q, key_edge;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   len, len_nxt, addr_inc;
    logic              full;
    logic              have_l, have_r;
    logic [15:0]       smp_l, smp_r;
    logic [31:0]       wdata;
    logic [15:0]       dac_l, dac_r;
    logic              dac_l_vld, dac_r_vld;
    logic              in_rec, in_play, nxt_play, wr_done, cap_l, cap_r, cap_both, out_both;
    logic              unused_in;

    assign unused_in = ^{KEY[3], SW[17:1]};
    assign key_edge  = KEY[2:0] & ~key_q;
    assign in_rec    = (state == REC_CAPTURE) || (state == REC_WRITE);
    assign in_play   = (state == PLAY_READ) || (state == PLAY_WAIT) || (state == PLAY_OUT);
    assign nxt_play  = (state_nxt == PLAY_READ) || (state_nxt == PLAY_WAIT) || (state_nxt == PLAY_OUT);
    assign wr_done   = (state == REC_WRITE) && !new_sdram_controller_0_s1_waitrequest;
    assign cap_l     = from_adc_left_channel_valid && from_adc_left_channel_ready;
    assign cap_r     = from_adc_right_channel_valid && from_adc_right_channel_ready;
    assign cap_both  = (state == REC_CAPTURE) && (have_l || cap_l) && (have_r || cap_r);
    assign out_both  = (state == PLAY_OUT) && (!dac_l_vld || to_dac_left_channel_ready)
                                           && (!dac_r_vld || to_dac_right_channel_ready);
    assign addr_inc  = {1'b0, addr} + 1'b1;
    // A write completing in the same cycle as a play request still counts toward the playable length.
    assign len_nxt   = wr_done ? addr_inc : len;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (key_edge[2]) begin
            state_nxt = IDLE;
        end else if (key_edge[1] && !in_play) begin
            state_nxt = (len_nxt != '0) ? PLAY_READ : IDLE;
        end else if (key_edge[0] && !in_rec) begin
            state_nxt = REC_CAPTURE;
        end else begin
            case (state)
                REC_CAPTURE: if (cap_both) state_nxt = REC_WRITE;
                REC_WRITE:   if (wr_done) state_nxt = (addr == MAX_ADDR) ? IDLE : REC_CAPTURE;
                PLAY_READ:   if (!new_sdram_controller_0_s1_waitrequest) state_nxt = PLAY_WAIT;
                PLAY_WAIT:   if (new_sdram_controller_0_s1_readdatavalid) state_nxt = PLAY_OUT;
                PLAY_OUT:    if (out_both) state_nxt = (addr_inc == len && !SW[0]) ? IDLE : PLAY_READ;
                default:     state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        new_sdram_controller_0_s1_chipselect = 1'b0;
        new_sdram_controller_0_s1_write_n    = 1'b1;
        new_sdram_controller_0_s1_read_n     = 1'b1;
        from_adc_left_channel_ready          = 1'b1;
        from_adc_right_channel_ready         = 1'b1;
        case (state)
            REC_CAPTURE: begin
                from_adc_left_channel_ready  = !have_l;
                from_adc_right_channel_ready = !have_r;
            end
            REC_WRITE: begin
                new_sdram_controller_0_s1_chipselect = 1'b1;
                new_sdram_controller_0_s1_write_n    = 1'b0;
                from_adc_left_channel_ready          = 1'b0;
                from_adc_right_channel_ready         = 1'b0;
            end
            PLAY_READ: begin
                new_sdram_controller_0_s1_chipselect = 1'b1;
                new_sdram_controller_0_s1_read_n     = 1'b0;
            end
            default: ;
        endcase
        LEDG = {6'b0, full, in_play, in_rec};
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            key_q     <= '0;
            addr      <= '0;
            len       <= '0;
            full      <= 1'b0;
            have_l    <= 1'b0;
            have_r    <= 1'b0;
            smp_l     <= '0;
            smp_r     <= '0;
            wdata     <= '0;
            dac_l     <= '0;
            dac_r     <= '0;
            dac_l_vld <= 1'b0;
            dac_r_vld <= 1'b0;
        end else begin
            key_q <= KEY[2:0];
            len   <= len_nxt;

            if (state_nxt == REC_CAPTURE && !in_rec)                      full <= 1'b0;
            else if (wr_done && addr == MAX_ADDR)                         full <= 1'b1;

            if (state_nxt == REC_CAPTURE && !in_rec)                      addr <= '0;
            else if (state_nxt == PLAY_READ && !in_play)                  addr <= '0;
            else if (wr_done && state_nxt == REC_CAPTURE)                 addr <= addr_inc[ADDR_W-1:0];
            else if (out_both && state_nxt == PLAY_READ)
                addr <= (addr_inc == len) ? '0 : addr_inc[ADDR_W-1:0];

            if (state == REC_CAPTURE && state_nxt == REC_CAPTURE) begin
                if (cap_l) begin have_l <= 1'b1; smp_l <= from_adc_left_channel_data;  end
                if (cap_r) begin have_r <= 1'b1; smp_r <= from_adc_right_channel_data; end
            end else begin
                have_l <= 1'b0;
                have_r <= 1'b0;
            end
            if (cap_both && state_nxt == REC_WRITE)
                wdata <= {have_l ? smp_l : from_adc_left_channel_data,
                          have_r ? smp_r : from_adc_right_channel_data};

            if (!nxt_play) begin
                dac_l_vld <= 1'b0;
                dac_r_vld <= 1'b0;
                dac_l     <= '0;
                dac_r     <= '0;
            end else if (state == PLAY_WAIT && state_nxt == PLAY_OUT) begin
                dac_l_vld <= 1'b1;
                dac_r_vld <= 1'b1;
                dac_l     <= new_sdram_controller_0_s1_readdata[31:16];
                dac_r     <= new_sdram_controller_0_s1_readdata[15:0];
            end else if (state == PLAY_OUT) begin
                if (to_dac_left_channel_ready)  dac_l_vld <= 1'b0;
                if (to_dac_right_channel_ready) dac_r_vld <= 1'b0;
            end
        end
    end

    assign new_sdram_controller_0_s1_address      = addr;
    assign new_sdram_controller_0_s1_writedata    = wdata;
    assign new_sdram_controller_0_s1_byteenable_n = 4'b0000;
    assign to_dac_left_channel_data               = dac_l;
    assign to_dac_right_channel_data              = dac_r;
    assign to_dac_left_channel_valid              = dac_l_vld;
    assign to_dac_right_channel_valid             = dac_r_vld;
endmodule

// File: tb/tb_acappella_core.sv
// Bench for acappella_core: random ADC/SDRAM/DAC traffic, scoreboard of expected writes, reads and DAC words.
module tb_acappella_core;
    localparam int             AW   = 23;
    localparam logic [AW-1:0]  MAXA = 23'd7;

    logic          i_clk = 1'b0, i_rst = 1'b0;
    logic [3:0]    key = '0;
    logic [17:0]   sw = '0;
    logic [8:0]    ledg;
    logic          adc_l_rdy, adc_r_rdy;
    logic [15:0]   adc_l_dat = '0, adc_r_dat = '0;
    logic          adc_l_vld = 1'b0, adc_r_vld = 1'b0;
    logic [15:0]   dac_l, dac_r;
    logic          dac_l_vld, dac_r_vld;
    logic          dac_l_rdy = 1'b0, dac_r_rdy = 1'b0;
    logic [AW-1:0] addr;
    logic [3:0]    be_n;
    logic          cs, rd_n, wr_n;
    logic [31:0]   wdata, rdata = '0;
    logic          rdv = 1'b0, waitreq = 1'b0;

    acappella_core #(.ADDR_W(AW), .MAX_ADDR(MAXA)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .KEY(key), .SW(sw), .LEDG(ledg),
        .from_adc_left_channel_ready(adc_l_rdy), .from_adc_left_channel_data(adc_l_dat),
        .from_adc_left_channel_valid(adc_l_vld),
        .from_adc_right_channel_ready(adc_r_rdy), .from_adc_right_channel_data(adc_r_dat),
        .from_adc_right_channel_valid(adc_r_vld),
        .to_dac_left_channel_data(dac_l), .to_dac_left_channel_valid(dac_l_vld),
        .to_dac_left_channel_ready(dac_l_rdy),
        .to_dac_right_channel_data(dac_r), .to_dac_right_channel_valid(dac_r_vld),
        .to_dac_right_channel_ready(dac_r_rdy),
        .new_sdram_controller_0_s1_address(addr), .new_sdram_controller_0_s1_byteenable_n(be_n),
        .new_sdram_controller_0_s1_chipselect(cs), .new_sdram_controller_0_s1_writedata(wdata),
        .new_sdram_controller_0_s1_read_n(rd_n), .new_sdram_controller_0_s1_write_n(wr_n),
        .new_sdram_controller_0_s1_readdata(rdata),
        .new_sdram_controller_0_s1_readdatavalid(rdv),
        .new_sdram_controller_0_s1_waitrequest(waitreq)
    );

    always #5 i_clk = ~i_clk;

    int            vecs = 0, errs = 0;
    int            wr_cnt = 0;
    bit            adc_on = 1'b0;
    bit            l_acc = 1'b0, r_acc = 1'b0;
    logic [15:0]   adc_lq[$], adc_rq[$];
    logic [15:0]   exp_l[$], exp_r[$];
    logic [AW-1:0] exp_ra[$];
    logic [31:0]   model_mem[16];
    logic [31:0]   sdram[16];
    logic [31:0]   mon_word, rd_word = '0;
    bit            rd_pend = 1'b0;
    int            rd_lat = 0;
    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [31:0]   prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        vecs++;
        errs++;
        $display("FAIL %s", name);
    endtask

    // Scoreboard monitor: samples every handshake on the falling edge.
    always @(negedge i_clk) begin
        l_acc = 1'b0;
        r_acc = 1'b0;
        if (i_rst) begin
            l_acc = adc_l_vld && adc_l_rdy;
            r_acc = adc_r_vld && adc_r_rdy;
            if (l_acc) adc_lq.push_back(adc_l_dat);
            if (r_acc) adc_rq.push_back(adc_r_dat);
            if (prev_stall && !wr_n) begin
                check("stall_addr", 32'(addr), 32'(prev_addr));
                check("stall_data", wdata, prev_data);
            end
            if (!wr_n && !waitreq) begin
                sdram[addr[3:0]] = wdata;
                if (adc_lq.size() == 0 || adc_rq.size() == 0) flag("wr_unexpected");
                else begin
                    mon_word = {adc_lq.pop_front(), adc_rq.pop_front()};
                    check("wr_addr", 32'(addr), 32'(wr_cnt));
                    check("wr_data", wdata, mon_word);
                    model_mem[wr_cnt[3:0]] = mon_word;
                    wr_cnt++;
                end
            end
            if (!rd_n && !waitreq) begin
                if (exp_ra.size() == 0) flag("rd_unexpected");
                else check("rd_addr", 32'(addr), 32'(exp_ra.pop_front()));
                check("rd_while_dac_busy", 32'({dac_l_vld, dac_r_vld}), 32'd0);
                rd_pend = 1'b1;
                rd_lat  = $urandom_range(1, 3);
                rd_word = sdram[addr[3:0]];
            end
            if (dac_l_vld && dac_l_rdy) begin
                if (exp_l.size() == 0) flag("dac_l_unexpected");
                else check("dac_l", 32'(dac_l), 32'(exp_l.pop_front()));
            end
            if (dac_r_vld && dac_r_rdy) begin
                if (exp_r.size() == 0) flag("dac_r_unexpected");
                else check("dac_r", 32'(dac_r), 32'(exp_r.pop_front()));
            end
            prev_stall = !wr_n && waitreq;
            prev_addr  = addr;
            prev_data  = wdata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Drivers for the SDRAM slave, ADC sources and DAC sinks.
    always begin
        @(posedge i_clk);
        #2;
        waitreq = ($urandom_range(0, 2) == 0);
        rdv     = 1'b0;
        rdata   = $urandom;
        if (rd_pend) begin
            if (rd_lat <= 1) begin
                rdv     = 1'b1;
                rdata   = rd_word;
                rd_pend = 1'b0;
            end else begin
                rd_lat--;
            end
        end
        if (!adc_on) begin
            adc_l_vld = 1'b0;
            adc_r_vld = 1'b0;
        end else begin
            if (!adc_l_vld || l_acc) begin
                adc_l_vld = ($urandom_range(0, 3) != 0);
                adc_l_dat = 16'($urandom);
            end
            if (!adc_r_vld || r_acc) begin
                adc_r_vld = ($urandom_range(0, 3) != 0);
                adc_r_dat = 16'($urandom);
            end
        end
        dac_l_rdy = (exp_l.size() > 0) && ($urandom_range(0, 2) != 0);
        dac_r_rdy = (exp_r.size() > 0) && ($urandom_range(0, 2) != 0);
    end

    task automatic press(input int b);
        @(posedge i_clk); #1 key[b] = 1'b1;
        @(posedge i_clk); #1 key[b] = 1'b0;
    endtask

    task automatic start_record();
        adc_lq.delete();
        adc_rq.delete();
        wr_cnt = 0;
        press(0);
        adc_on = 1'b1;
    endtask

    task automatic start_play(input int nrd, input int npair);
        @(posedge i_clk); #1;
        key[1] = 1'b1;
        adc_on = 1'b0;
        @(posedge i_clk); #1;
        adc_lq.delete();
        adc_rq.delete();
        if (wr_cnt == 0) flag("play_no_length");
        else begin
            for (int i = 0; i < nrd; i++) exp_ra.push_back(AW'(i % wr_cnt));
            for (int i = 0; i < npair; i++) begin
                exp_l.push_back(model_mem[i % wr_cnt][31:16]);
                exp_r.push_back(model_mem[i % wr_cnt][15:0]);
            end
        end
        key[1] = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        int t = 0;
        while (wr_cnt < n && t < 5000) begin @(negedge i_clk); t++; end
        if (wr_cnt < n) flag("timeout_writes");
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_l.size() + exp_r.size() + exp_ra.size()) != 0 && t < 5000) begin
            @(negedge i_clk); t++;
        end
        if (t >= 5000) flag("timeout_drain");
    endtask

    task automatic wait_idle();
        int t = 0;
        while (ledg[1:0] != 2'b00 && t < 5000) begin @(negedge i_clk); t++; end
        if (t >= 5000) flag("timeout_idle");
    endtask

    initial begin
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_ledg", 32'(ledg), 32'd0);
        check("rst_strobes", 32'({cs, rd_n, wr_n}), 32'b011);
        check("rst_be_n", 32'(be_n), 32'd0);
        check("rst_dac", 32'({dac_l_vld, dac_r_vld, dac_l, dac_r}), 32'd0);
        check("rst_addr_wdata", 32'(addr) | wdata, 32'd0);
        check("rst_adc_rdy", 32'({adc_l_rdy, adc_r_rdy}), 32'b11);
        i_rst = 1'b1;

        // Play with nothing recorded stays idle and issues no read.
        press(1);
        repeat (4) @(negedge i_clk);
        check("empty_play_ledg", 32'(ledg), 32'd0);

        // Record, stop with KEY[2], then one-shot playback.
        start_record();
        wait_writes(5);
        @(negedge i_clk);
        check("rec_ledg", 32'(ledg), 32'h001);
        press(2);
        adc_on = 1'b0;
        @(negedge i_clk);
        check("stop_rec_ledg", 32'(ledg), 32'd0);
        sw[0] = 1'b0;
        start_play(wr_cnt, wr_cnt);
        wait_drain();
        wait_idle();
        @(negedge i_clk);
        check("play_end_ledg", 32'(ledg), 32'd0);
        check("play_end_dac", 32'({dac_l_vld, dac_r_vld, dac_l, dac_r}), 32'd0);

        // Looping playback wraps to address 0; hold the sink, then stop.
        sw[0] = 1'b1;
        start_play(2 * wr_cnt + 1, 2 * wr_cnt);
        wait_drain();
        repeat (6) @(negedge i_clk);
        check("loop_ledg", 32'(ledg), 32'h002);
        check("loop_hold_vld", 32'({dac_l_vld, dac_r_vld}), 32'b11);
        check("loop_wrap_word", {dac_l, dac_r}, model_mem[0]);
        @(posedge i_clk); #1 key[2] = 1'b1;
        @(posedge i_clk); #1;
        check("stop_play_ledg", 32'(ledg), 32'd0);
        check("stop_play_bus", 32'({dac_l_vld, dac_r_vld, cs, rd_n, wr_n}), 32'b00011);
        key[2] = 1'b0;
        sw[0] = 1'b0;

        // KEY[1] during recording ends it and plays from address 0.
        start_record();
        wait_writes(3);
        start_play(wr_cnt, wr_cnt);
        wait_drain();
        wait_idle();
        @(negedge i_clk);
        check("rec_to_play_end", 32'(ledg), 32'd0);

        // Record until the memory is full.
        start_record();
        begin
            int t = 0;
            while (!ledg[2] && t < 5000) begin @(negedge i_clk); t++; end
            if (t >= 5000) flag("timeout_full");
        end
        check("full_ledg", 32'(ledg), 32'h004);
        adc_on = 1'b0;
        repeat (2) @(negedge i_clk);
        check("full_count", 32'(wr_cnt), 32'(MAXA) + 32'd1);
        start_play(wr_cnt, wr_cnt);
        wait_drain();
        wait_idle();
        @(negedge i_clk);
        check("full_play_ledg", 32'(ledg), 32'h004);

        // New recording clears full; reset mid-record releases everything at once.
        start_record();
        wait_writes(2);
        @(negedge i_clk);
        check("rec_clears_full", 32'(ledg), 32'h001);
        @(posedge i_clk); #3 i_rst = 1'b0;
        #1;
        check("midrst_strobes", 32'({cs, rd_n, wr_n}), 32'b011);
        check("midrst_ledg", 32'(ledg), 32'd0);
        check("midrst_dac_vld", 32'({dac_l_vld, dac_r_vld}), 32'd0);
        adc_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
